// File: rtl/spi_mem_pkg.sv
// Shared widths, R/W encoding and FSM states for the spimemory SPI master.
package spi_mem_pkg;

    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam int FRAME_W = 16;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock generator: CLKDIV system clocks per sclk half-period, low first after enable.
module spi_sclk_gen #(
    parameter int CLKDIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall,
    output logic period_done
);

    localparam int PHASE_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CLKDIV - 1);

    logic [PHASE_W-1:0] phase;
    logic               half_done;

    // Strobes mark the clk edge on which sclk is about to toggle.
    assign half_done   = en && (phase == PHASE_LAST);
    assign rise        = half_done && !sclk;
    assign fall        = half_done && sclk;
    assign period_done = fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= '0;
            sclk  <= 1'b0;
        end else if (!en) begin
            phase <= '0;
            sclk  <= 1'b0;
        end else if (half_done) begin
            phase <= '0;
            sclk  <= !sclk;
        end else begin
            phase <= phase + PHASE_W'(1);
        end
    end

endmodule

// File: rtl/spi_mem_master.sv
// Bus-side SPI master: turns one word read/write request into a 16-bit spimemory frame,
// then holds cs high for IDLE_CYCLES sclk periods so the slave can return to its start state.
module spi_mem_master
    import spi_mem_pkg::*;
#(
    parameter int CLKDIV      = 4,
    parameter int IDLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              sclk,
    output logic              cs,
    output logic              mosi_pin,
    input  logic              miso_pin
);

    localparam int GAP_W = ($clog2(2 * IDLE_CYCLES) > 0) ? $clog2(2 * IDLE_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(2 * IDLE_CYCLES - 1);

    state_t               state;
    state_t               next_state;
    logic [FRAME_W-2:0]   frame_tail;
    logic [DATA_W-1:0]    rdata;
    logic [3:0]           bit_cnt;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 is_read;
    logic                 accept;
    logic                 last_slot;
    logic                 sclk_rise;
    logic                 sclk_fall;
    logic                 sclk_period_done;

    assign req_ready = (state == IDLE);
    assign busy      = !req_ready;
    assign accept    = req_valid && req_ready;
    assign last_slot = (bit_cnt == 4'd15);

    spi_sclk_gen #(
        .CLKDIV(CLKDIV)
    ) u_sclk_gen (
        .clk        (clk),
        .reset      (reset),
        .en         (state != IDLE),
        .sclk       (sclk),
        .rise       (sclk_rise),
        .fall       (sclk_fall),
        .period_done(sclk_period_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (accept) next_state = SHIFT;
            SHIFT:   if (sclk_fall && last_slot) next_state = GAP;
            GAP:     if (sclk_period_done && (gap_cnt == GAP_LAST)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The first frame bit goes straight to mosi_pin on accept; frame_tail holds the rest.
    // Read frames carry zeros in the data slots regardless of req_wdata.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_tail <= '0;
            rdata      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            is_read    <= 1'b0;
            cs         <= 1'b1;
            mosi_pin   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        frame_tail <= {req_addr[ADDR_W-2:0], req_rw,
                                       (req_rw == RW_READ) ? {DATA_W{1'b0}} : req_wdata};
                        is_read    <= (req_rw == RW_READ);
                        mosi_pin   <= req_addr[ADDR_W-1];
                        cs         <= 1'b0;
                        bit_cnt    <= '0;
                    end
                end
                SHIFT: begin
                    if (sclk_rise && bit_cnt[3]) begin
                        rdata <= {rdata[DATA_W-2:0], miso_pin};
                    end
                    if (sclk_fall) begin
                        if (last_slot) begin
                            cs        <= 1'b1;
                            mosi_pin  <= 1'b0;
                            rsp_valid <= 1'b1;
                            gap_cnt   <= '0;
                            if (is_read) begin
                                rsp_rdata <= rdata;
                            end
                        end else begin
                            mosi_pin   <= frame_tail[FRAME_W-2];
                            frame_tail <= {frame_tail[FRAME_W-3:0], 1'b0};
                            bit_cnt    <= bit_cnt + 4'd1;
                        end
                    end
                end
                GAP: begin
                    if (sclk_rise || sclk_fall) begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_master.sv
// Directed bench for spi_mem_master: lane 0 uses the default timing, lane 1 CLKDIV=1/IDLE_CYCLES=1,
// each with a behavioural spimemory slave and a cs/sclk/mosi protocol watcher.
module tb_spi_mem_master;
    import spi_mem_pkg::*;

    typedef struct {
        int          lane;
        logic        rw;
        logic [6:0]  addr;
        logic [7:0]  wdata;
        logic [15:0] exp_frame;
        logic [7:0]  exp_rdata;
        int          exp_rsp;
        int          exp_rdy;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req_valid = '0;
    logic [1:0] req_rw = '0;
    logic [6:0] req_addr [2];
    logic [7:0] req_wdata [2];
    wire  [1:0] req_ready, rsp_valid, busy, sclk, cs, mosi;
    wire  [7:0] rsp_rdata [2];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        logic [7:0]  mem [128] = '{default: 8'h00};
        logic [4:0]  s_cnt = '0;
        logic [15:0] s_shift = '0;
        logic [15:0] cap_frame = '0;
        logic [7:0]  s_out = '0;
        logic        s_miso = 1'b0;
        logic        p_cs = 1'b1;
        logic        p_sclk = 1'b0;
        logic        p_mosi = 1'b0;
        int          viol = 0;

        spi_mem_master #(
            .CLKDIV     (g == 0 ? 4 : 1),
            .IDLE_CYCLES(g == 0 ? 2 : 1)
        ) dut (
            .clk      (clk),
            .reset    (reset),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_rw   (req_rw[g]),
            .req_addr (req_addr[g]),
            .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_rdata(rsp_rdata[g]),
            .busy     (busy[g]),
            .sclk     (sclk[g]),
            .cs       (cs[g]),
            .mosi_pin (mosi[g]),
            .miso_pin (s_miso)
        );

        // Slave: samples mosi on sclk rise, commits writes on the 16th bit.
        always @(posedge sclk[g] or posedge cs[g]) begin
            if (cs[g]) begin
                s_cnt <= '0;
            end else begin
                s_shift <= {s_shift[14:0], mosi[g]};
                s_cnt   <= s_cnt + 5'd1;
                if (s_cnt == 5'd15) begin
                    cap_frame <= {s_shift[14:0], mosi[g]};
                    if (s_shift[7] == RW_WRITE) mem[s_shift[14:8]] <= {s_shift[6:0], mosi[g]};
                end
            end
        end

        // Slave read data changes on sclk fall so it is settled before the next rise.
        always @(negedge sclk[g]) begin
            if (cs[g] == 1'b0) begin
                if (s_cnt == 5'd8 && s_shift[0] == RW_READ) begin
                    s_miso <= mem[s_shift[7:1]][7];
                    s_out  <= {mem[s_shift[7:1]][6:0], 1'b0};
                end else if (s_cnt > 5'd8) begin
                    s_miso <= s_out[7];
                    s_out  <= {s_out[6:0], 1'b0};
                end
            end
        end

        always @(negedge clk) begin
            if (!reset) begin
                viol <= viol + ((cs[g] != p_cs && sclk[g]) ? 1 : 0)
                             + ((sclk[g] && !p_sclk && mosi[g] != p_mosi) ? 1 : 0);
            end
            p_cs   <= cs[g];
            p_sclk <= sclk[g];
            p_mosi <= mosi[g];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    function automatic logic [15:0] getFrame(input int lane);
        return (lane == 0) ? g_lane[0].cap_frame : g_lane[1].cap_frame;
    endfunction

    task automatic applyStimulus(input int lane, input logic rw, input logic [6:0] addr, input logic [7:0] wdata);
        @(negedge clk);
        req_rw[lane]    = rw;
        req_addr[lane]  = addr;
        req_wdata[lane] = wdata;
        req_valid[lane] = 1'b1;
        @(posedge clk);
    endtask

    // Starts just after the accepting edge; cycle n is the n-th negedge sample after it.
    task automatic waitFrame(input int lane, output int rsp_cyc, output int rdy_cyc,
                             output int rsp_cnt, output logic [7:0] rd);
        int n = 0;
        rsp_cyc = -1;
        rdy_cyc = -1;
        rsp_cnt = 0;
        rd      = 8'h00;
        while (n < 400 && rdy_cyc < 0) begin
            @(negedge clk);
            n++;
            if (n == 1) req_valid[lane] = 1'b0;
            if (rsp_valid[lane]) begin
                rsp_cnt++;
                rsp_cyc = n;
                rd      = rsp_rdata[lane];
            end
            if (req_ready[lane]) rdy_cyc = n;
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t       vecs [8];
        int         rsp_cyc, rdy_cyc, rsp_cnt, n, second, gap_rises, stray;
        logic [7:0] rd;
        logic       prev_s;

        vecs[0] = '{0, RW_WRITE, 7'h00, 8'hAA, 16'h00AA, 8'h00, 129, 145};
        vecs[1] = '{0, RW_READ,  7'h00, 8'h00, 16'h0100, 8'hAA, 129, 145};
        vecs[2] = '{0, RW_WRITE, 7'h12, 8'h3C, 16'h243C, 8'hAA, 129, 145};
        vecs[3] = '{0, RW_READ,  7'h12, 8'h00, 16'h2500, 8'h3C, 129, 145};
        vecs[4] = '{0, RW_WRITE, 7'h7F, 8'h81, 16'hFE81, 8'h3C, 129, 145};
        vecs[5] = '{0, RW_READ,  7'h7F, 8'hFF, 16'hFF00, 8'h81, 129, 145};
        vecs[6] = '{1, RW_WRITE, 7'h7F, 8'hC3, 16'hFEC3, 8'h00, 33, 35};
        vecs[7] = '{1, RW_READ,  7'h7F, 8'h00, 16'hFF00, 8'hC3, 33, 35};

        for (int l = 0; l < 2; l++) begin
            req_addr[l]  = 7'h00;
            req_wdata[l] = 8'h00;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int l = 0; l < 2; l++) begin
            checkOutput($sformatf("rst%0d_cs", l), 32'(cs[l]), 32'd1);
            checkOutput($sformatf("rst%0d_sclk", l), 32'(sclk[l]), 32'd0);
            checkOutput($sformatf("rst%0d_mosi", l), 32'(mosi[l]), 32'd0);
            checkOutput($sformatf("rst%0d_rsp_valid", l), 32'(rsp_valid[l]), 32'd0);
            checkOutput($sformatf("rst%0d_rsp_rdata", l), 32'(rsp_rdata[l]), 32'h00);
            checkOutput($sformatf("rst%0d_req_ready", l), 32'(req_ready[l]), 32'd1);
            checkOutput($sformatf("rst%0d_busy", l), 32'(busy[l]), 32'd0);
        end

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].lane, vecs[i].rw, vecs[i].addr, vecs[i].wdata);
            waitFrame(vecs[i].lane, rsp_cyc, rdy_cyc, rsp_cnt, rd);
            checkOutput($sformatf("v%0d_frame", i), 32'(getFrame(vecs[i].lane)), 32'(vecs[i].exp_frame));
            checkOutput($sformatf("v%0d_rsp_cycle", i), rsp_cyc, vecs[i].exp_rsp);
            checkOutput($sformatf("v%0d_rsp_count", i), rsp_cnt, 1);
            checkOutput($sformatf("v%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
            checkOutput($sformatf("v%0d_ready_cycle", i), rdy_cyc, vecs[i].exp_rdy);
        end

        // Back-to-back with req_valid held high: write 0x55 to 0x05 then read it.
        applyStimulus(0, RW_WRITE, 7'h05, 8'h55);
        n = 0; second = -1; gap_rises = 0; rsp_cyc = -1; prev_s = 1'b0;
        while (n < 400 && second < 0) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                req_rw[0]    = RW_READ;
                req_addr[0]  = 7'h05;
                req_wdata[0] = 8'h00;
            end
            if (rsp_valid[0]) rsp_cyc = n;
            if (req_ready[0]) second = n;
            if (cs[0] && sclk[0] && !prev_s) gap_rises++;
            prev_s = sclk[0];
        end
        checkOutput("b2b_first_rsp_cycle", rsp_cyc, 129);
        checkOutput("b2b_first_frame", 32'(getFrame(0)), 32'h0A55);
        checkOutput("b2b_second_accept_cycle", second, 145);
        checkOutput("b2b_gap_sclk_periods", gap_rises, 2);
        @(posedge clk);
        waitFrame(0, rsp_cyc, rdy_cyc, rsp_cnt, rd);
        checkOutput("b2b_read_frame", 32'(getFrame(0)), 32'h0B00);
        checkOutput("b2b_read_rsp_cycle", rsp_cyc, 129);
        checkOutput("b2b_read_rdata", 32'(rd), 32'h55);

        // Reset during the high phase of slot 9 of a read.
        applyStimulus(0, RW_READ, 7'h05, 8'h00);
        stray = 0;
        for (int c = 1; c <= 78; c++) begin
            @(negedge clk);
            if (c == 1) req_valid[0] = 1'b0;
            if (rsp_valid[0]) stray++;
        end
        checkOutput("midrst_pre_sclk", 32'(sclk[0]), 32'd1);
        checkOutput("midrst_pre_cs", 32'(cs[0]), 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("midrst_cs", 32'(cs[0]), 32'd1);
        checkOutput("midrst_sclk", 32'(sclk[0]), 32'd0);
        checkOutput("midrst_mosi", 32'(mosi[0]), 32'd0);
        checkOutput("midrst_rsp_rdata", 32'(rsp_rdata[0]), 32'h00);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 160; c++) begin
            @(negedge clk);
            if (rsp_valid[0]) stray++;
        end
        checkOutput("midrst_no_rsp", stray, 0);
        checkOutput("midrst_ready", 32'(req_ready[0]), 32'd1);
        checkOutput("midrst_cs_idle", 32'(cs[0]), 32'd1);

        applyStimulus(0, RW_READ, 7'h05, 8'hFF);
        waitFrame(0, rsp_cyc, rdy_cyc, rsp_cnt, rd);
        checkOutput("recover_frame", 32'(getFrame(0)), 32'h0B00);
        checkOutput("recover_rsp_cycle", rsp_cyc, 129);
        checkOutput("recover_rdata", 32'(rd), 32'h55);
        checkOutput("recover_ready_cycle", rdy_cyc, 145);

        @(negedge clk);
        checkOutput("protocol_lane0", g_lane[0].viol, 0);
        checkOutput("protocol_lane1", g_lane[1].viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
